pipeline_ctrl_gen2: RTL and testbench

PIPELINE_CTRL_GEN2 -- requirements
Module: pipeline_ctrl_gen2

---
 rtl/mak8_pipe_pkg.sv | 17 +
 rtl/branch_cond_eval.sv | 26 ++
 rtl/pipeline_ctrl_gen2.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl_gen2.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mak8_pipe_pkg.sv
// rtl/mak8_pipe_pkg.sv - shared FSM state and branch-condition encodings for the pipeline controller
package mak8_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluation on the Execute-stage operands
module branch_cond_eval
  import mak8_pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (br_cond)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) < $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 < rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl_gen2.sv
// rtl/pipeline_ctrl_gen2.sv - pipeline control FSM (redirect/flush, load-use stall, halt); perf counters with PIPE_CTRL_PERF_EN
module pipeline_ctrl_gen2
  import mak8_pipe_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic              ex_halt,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [ADDR_W-1:0] imm_ext,
  input  logic              id_valid,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              resume,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_offset,
  output logic              stall,
  output logic              flush,
  output logic              cpu_halt,
  output logic              mem_enable,
  output logic              reg_enable,
  output logic [1:0]        state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_branch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       taken, run, redirect, halt_req, hazard;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .br_cond (br_cond),
    .rs1     (rs1_data),
    .rs2     (rs2_data),
    .taken   (taken)
  );

  // rst_n gating holds the combinational outputs at their reset values while reset is low.
  assign run      = rst_n && (state_q == ST_RUN);
  assign halt_req = run && ex_valid && ex_halt;
  assign redirect = run && ex_valid && !ex_halt && (ex_jump || (ex_branch && taken));
  assign hazard   = ex_valid && ex_load && id_valid &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_load    = redirect;
    pc_offset  = redirect ? imm_ext : ADDR_W'(1);
    stall      = run && hazard && !redirect;
    flush      = redirect || (state_q == ST_FLUSH);
    cpu_halt   = (state_q == ST_HALT);
    mem_enable = (state_q != ST_HALT);
    reg_enable = (state_q != ST_HALT);
    state_o    = state_q;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_branch_q, perf_branch_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_branch_d = perf_branch_q;
    perf_stall_d  = perf_stall_q;
    if (redirect && !(&perf_branch_q)) perf_branch_d = perf_branch_q + 1'b1;
    if (stall && !(&perf_stall_q))     perf_stall_d  = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_branch_q <= perf_branch_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_branch_cnt = perf_branch_q;
  assign perf_stall_cnt  = perf_stall_q;
`else
  if (PERF_W < 1) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl_gen2.sv
// tb/tb_pipeline_ctrl_gen2.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_pipeline_ctrl_gen2;
  localparam int DW = 8, AW = 16, RW = 3, FC = 3, PW = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid, ex_branch, ex_jump, ex_halt, ex_load;
  logic [RW-1:0] ex_rd, id_rs1, id_rs2;
  logic [2:0] br_cond;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [AW-1:0] imm_ext, pc_offset;
  logic id_valid, id_uses_rs2, resume;
  logic pc_load, stall, flush, cpu_halt, mem_enable, reg_enable;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] perf_branch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl_gen2 #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_halt(ex_halt), .ex_load(ex_load),
    .ex_rd(ex_rd), .br_cond(br_cond), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ext(imm_ext),
    .id_valid(id_valid), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2), .resume(resume),
    .pc_load(pc_load), .pc_offset(pc_offset), .stall(stall), .flush(flush),
    .cpu_halt(cpu_halt), .mem_enable(mem_enable), .reg_enable(reg_enable), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_branch_cnt(perf_branch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic ev, eb, ej, eh, el;
    logic [2:0] rd, bc, r1, r2;
    logic [7:0] a, b;
    logic [15:0] imm;
    logic iv, iu, rsm;
  } in_t;

  typedef struct {
    string name;
    in_t i;
    logic pl;
    logic [15:0] po;
    logic st, fl;
  } vec_t;

  typedef struct {
    logic pl, st, fl, h;
    logic [15:0] po;
    logic [1:0] so;
  } out_t;

  int checks = 0, errors = 0;
  in_t cur, idle;
  vec_t vq[$];

  // Reference model: mode 0=run 1=flush 2=halt, flush_left = flush cycles still owed
  int m_mode = 0, m_left = 0, m_br = 0, m_stl = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sval(logic [7:0] v);
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic bit m_taken(logic [2:0] bc, logic [7:0] a, logic [7:0] b);
    case (bc)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sval(a) < sval(b);
      3'd3: return sval(a) >= sval(b);
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t model_out(in_t x);
    out_t o;
    bit run, redir, haz;
    run   = (m_mode == 0) && (rst_n === 1'b1);
    redir = run && x.ev && !x.eh && (x.ej || (x.eb && m_taken(x.bc, x.a, x.b)));
    haz   = x.ev && x.el && x.iv && (x.rd == x.r1 || (x.iu && x.rd == x.r2));
    o.pl  = redir;
    o.po  = redir ? x.imm : 16'd1;
    o.st  = run && haz && !redir;
    o.fl  = redir || (m_mode == 1);
    o.h   = (m_mode == 2);
    o.so  = 2'(m_mode);
    return o;
  endfunction

  task automatic model_adv(in_t x, out_t o);
    if (o.pl && m_br < PMAX) m_br++;
    if (o.st && m_stl < PMAX) m_stl++;
    case (m_mode)
      0: if (x.ev && x.eh) m_mode = 2;
         else if (o.pl && FC > 1) begin m_mode = 1; m_left = FC - 1; end
      1: begin if (m_left == 1) m_mode = 0; m_left--; end
      default: if (x.rsm) m_mode = 0;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_br = 0; m_stl = 0;
  endtask

  task automatic apply(in_t x);
    cur = x;
    ex_valid = x.ev; ex_branch = x.eb; ex_jump = x.ej; ex_halt = x.eh; ex_load = x.el;
    ex_rd = x.rd; br_cond = x.bc; rs1_data = x.a; rs2_data = x.b; imm_ext = x.imm;
    id_valid = x.iv; id_uses_rs2 = x.iu; id_rs1 = x.r1; id_rs2 = x.r2; resume = x.rsm;
  endtask

  task automatic check_all(string tag);
    out_t o;
    o = model_out(cur);
    chk({tag, ".pc_load"}, pc_load, o.pl);
    chk({tag, ".pc_offset"}, pc_offset, o.po);
    chk({tag, ".stall"}, stall, o.st);
    chk({tag, ".flush"}, flush, o.fl);
    chk({tag, ".cpu_halt"}, cpu_halt, o.h);
    chk({tag, ".mem_enable"}, mem_enable, !o.h);
    chk({tag, ".reg_enable"}, reg_enable, !o.h);
    chk({tag, ".state_o"}, state_o, o.so);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, ".perf_branch"}, perf_branch_cnt, m_br);
    chk({tag, ".perf_stall"}, perf_stall_cnt, m_stl);
`endif
  endtask

  // Time invariant between steps: 1 unit after a rising edge.
  task automatic tick();
    out_t o;
    o = model_out(cur);
    @(posedge clk);
    model_adv(cur, o);
    #1;
  endtask

  task automatic step(in_t x, string tag);
    apply(x); #3; check_all(tag); tick();
  endtask

  task automatic async_reset(string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, ".flush_low"}, flush, 1'b0);
    chk({tag, ".state_run"}, state_o, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic in_t mk(logic ev, logic eb, logic ej, logic eh, logic el, logic [2:0] rd,
                             logic [2:0] bc, logic [7:0] a, logic [7:0] b, logic [15:0] imm,
                             logic iv, logic iu, logic [2:0] r1, logic [2:0] r2);
    in_t x;
    x.ev = ev; x.eb = eb; x.ej = ej; x.eh = eh; x.el = el; x.rd = rd; x.bc = bc;
    x.a = a; x.b = b; x.imm = imm; x.iv = iv; x.iu = iu; x.r1 = r1; x.r2 = r2; x.rsm = 1'b0;
    return x;
  endfunction

  task automatic add(string n, in_t i, logic pl, logic [15:0] po, logic st, logic fl);
    vec_t v;
    v.name = n; v.i = i; v.pl = pl; v.po = po; v.st = st; v.fl = fl;
    vq.push_back(v);
  endtask

  in_t x;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    apply(idle);
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    //  name         ev eb ej eh el rd bc    a      b      imm       iv iu r1 r2      pl  po         st fl
    add("blt_taken",  mk(1, 1, 0, 0, 0, 0, 3'd2, 8'hFF, 8'h01, 16'h0010, 0, 0, 0, 0), 1, 16'h0010, 0, 1);
    add("bltu_not",   mk(1, 1, 0, 0, 0, 0, 3'd4, 8'hFF, 8'h01, 16'h0010, 0, 0, 0, 0), 0, 16'h0001, 0, 0);
    add("beq_taken",  mk(1, 1, 0, 0, 0, 0, 3'd0, 8'h05, 8'h05, 16'h0020, 0, 0, 0, 0), 1, 16'h0020, 0, 1);
    add("bne_not",    mk(1, 1, 0, 0, 0, 0, 3'd1, 8'h05, 8'h05, 16'h0020, 0, 0, 0, 0), 0, 16'h0001, 0, 0);
    add("bge_taken",  mk(1, 1, 0, 0, 0, 0, 3'd3, 8'h01, 8'hFF, 16'h0030, 0, 0, 0, 0), 1, 16'h0030, 0, 1);
    add("bgeu_not",   mk(1, 1, 0, 0, 0, 0, 3'd5, 8'h01, 8'hFF, 16'h0030, 0, 0, 0, 0), 0, 16'h0001, 0, 0);
    add("cond6_never",mk(1, 1, 0, 0, 0, 0, 3'd6, 8'h01, 8'h01, 16'h0040, 0, 0, 0, 0), 0, 16'h0001, 0, 0);
    add("jump",       mk(1, 0, 1, 0, 0, 0, 3'd7, 8'h00, 8'h00, 16'hFFFC, 0, 0, 0, 0), 1, 16'hFFFC, 0, 1);
    add("lu_rs1",     mk(1, 0, 0, 0, 1, 3, 3'd6, 8'h00, 8'h00, 16'h0050, 1, 0, 3, 0), 0, 16'h0001, 1, 0);
    add("lu_rs2_nouse",mk(1, 0, 0, 0, 1, 3, 3'd6, 8'h00, 8'h00, 16'h0050, 1, 0, 0, 3), 0, 16'h0001, 0, 0);
    add("lu_rs2_use", mk(1, 0, 0, 0, 1, 3, 3'd6, 8'h00, 8'h00, 16'h0050, 1, 1, 0, 3), 0, 16'h0001, 1, 0);
    add("lu_vs_jump", mk(1, 0, 1, 0, 1, 3, 3'd6, 8'h00, 8'h00, 16'h0060, 1, 0, 3, 0), 1, 16'h0060, 0, 1);
    add("invalid_jmp",mk(0, 0, 1, 0, 1, 3, 3'd6, 8'h00, 8'h00, 16'h0070, 1, 0, 3, 0), 0, 16'h0001, 0, 0);

    foreach (vq[k]) begin
      apply(vq[k].i);
      #3;
      chk({vq[k].name, ".v_pc_load"}, pc_load, vq[k].pl);
      chk({vq[k].name, ".v_pc_offset"}, pc_offset, vq[k].po);
      chk({vq[k].name, ".v_stall"}, stall, vq[k].st);
      chk({vq[k].name, ".v_flush"}, flush, vq[k].fl);
      check_all(vq[k].name);
      tick();
      repeat (FC) step(idle, "drain");
    end

    // Jump with FFFC: one pc_load cycle, flush for exactly FC cycles, ex/id inputs ignored in FLUSH
    x = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFC, 0, 0, 0, 0);
    apply(x); #3;
    chk("seqj.c0_pc_load", pc_load, 1'b1);
    chk("seqj.c0_offset", pc_offset, 16'hFFFC);
    chk("seqj.c0_flush", flush, 1'b1);
    tick();
    x = mk(1, 1, 1, 1, 1, 3, 0, 1, 1, 16'h1234, 1, 1, 3, 3);
    for (int c = 1; c < FC; c++) begin
      apply(x); #3;
      chk("seqj.fl_pc_load", pc_load, 1'b0);
      chk("seqj.fl_stall", stall, 1'b0);
      chk("seqj.fl_flush", flush, 1'b1);
      chk("seqj.fl_state", state_o, 2'b01);
      check_all("seqj.fl");
      tick();
    end
    apply(idle); #3;
    chk("seqj.end_flush", flush, 1'b0);
    chk("seqj.end_state", state_o, 2'b00);
    tick();

    // Halt wins over same-cycle jump, then HALT until resume
    x = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0040, 0, 0, 0, 0);
    apply(x); #3;
    chk("seqh.pc_load", pc_load, 1'b0);
    chk("seqh.flush", flush, 1'b0);
    tick();
    x = mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 16'h0044, 1, 0, 2, 0);
    apply(x); #3;
    chk("seqh.cpu_halt", cpu_halt, 1'b1);
    chk("seqh.mem_enable", mem_enable, 1'b0);
    chk("seqh.halt_pc_load", pc_load, 1'b0);
    chk("seqh.halt_stall", stall, 1'b0);
    check_all("seqh.halted");
    tick();
    x = idle; x.rsm = 1'b1;
    apply(x); #3;
    chk("seqh.pre_resume", state_o, 2'b10);
    tick();
    apply(idle); #3;
    chk("seqh.resumed", state_o, 2'b00);
    chk("seqh.resumed_halt", cpu_halt, 1'b0);
    tick();

    // Asynchronous reset mid-FLUSH and mid-HALT, with a redirecting instruction still presented
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0008, 0, 0, 0, 0), "pre_rst_flush");
    x = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 16'h0008, 1, 0, 1, 0);
    apply(x);
    async_reset("rst_in_flush");
    step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "pre_rst_halt");
    apply(x);
    async_reset("rst_in_halt");
    step(idle, "post_rst");

    for (int n = 0; n < 1500; n++) begin
      x.ev = ($urandom_range(0, 3) != 0);
      x.eb = $urandom_range(0, 1);
      x.ej = ($urandom_range(0, 3) == 0);
      x.eh = ($urandom_range(0, 15) == 0);
      x.el = $urandom_range(0, 1);
      x.rd = 3'($urandom);
      x.bc = 3'($urandom);
      x.a  = 8'($urandom);
      x.b  = ($urandom_range(0, 3) == 0) ? x.a : 8'($urandom);
      x.imm = 16'($urandom);
      x.iv = $urandom_range(0, 1);
      x.iu = $urandom_range(0, 1);
      x.r1 = 3'($urandom);
      x.r2 = 3'($urandom);
      x.rsm = ($urandom_range(0, 3) == 0);
      step(x, "rand");
    end

`ifdef PIPE_CTRL_PERF_EN
    apply(idle);
    async_reset("perf_rst");
    for (int n = 0; n < 20; n++) begin
      step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0004, 0, 0, 0, 0), "perf_jump");
      repeat (FC - 1) step(idle, "perf_drain");
    end
    #3;
    chk("perf.branch_sat", perf_branch_cnt, 4'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
